// File: rtl/yuv_block_reader.sv
// ============================================================================
//  Module   : yuv_block_reader
//  Function : Fetches one 8x8 pixel block from SRAM into 64 level-shifted DPRAM entries.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module yuv_block_reader #(
   parameter logic [17:0] Y_BASE = 18'd0,
   parameter logic [17:0] U_BASE = 18'd38400,
   parameter logic [17:0] V_BASE = 18'd57600
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Start,
   output logic [17:0] SRAM_address,
   input  logic [15:0] SRAM_read_data,
   output logic        SRAM_we_n,
   output logic [6:0]  DP_address,
   output logic [31:0] DP_write_data,
   output logic        DP_we,
   output logic        Busy,
   output logic        Block_done,
   output logic        Frame_done
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

   localparam logic [1:0] c_PL_Y = 2'd0;
   localparam logic [1:0] c_PL_U = 2'd1;
   localparam logic [1:0] c_PL_V = 2'd2;

   state_t      r_state;
   logic [6:0]  r_cyc;     // cycle index from the first FETCH cycle; equals k during FETCH
   logic [1:0]  r_plane;
   logic [5:0]  r_bx;
   logic [4:0]  r_by;
   logic [7:0]  r_low;

   logic [17:0] w_stride;
   logic [17:0] w_plane_base;
   logic [17:0] w_block_addr;
   logic [17:0] w_word_addr;
   logic [6:0]  w_n;
   logic        w_bx_last;
   logic        w_by_last;
   logic        w_dp_we_next;
   logic [7:0]  w_pix;

   assign SRAM_we_n = 1'b1;

   always_comb begin
      w_stride     = (r_plane == c_PL_Y) ? 18'd160 : 18'd80;
      w_plane_base = Y_BASE;
      if (r_plane == c_PL_U) w_plane_base = U_BASE;
      if (r_plane == c_PL_V) w_plane_base = V_BASE;
      w_block_addr = w_plane_base + w_stride * {10'd0, r_by, 3'd0} + {10'd0, r_bx, 2'd0};
      // Cycle about to begin: word n/2 sits at row n[5:3], column n[2:1] of the block
      w_n          = (r_state == S_IDLE) ? 7'd0 : r_cyc + 7'd1;
      w_word_addr  = w_block_addr + w_stride * {15'd0, w_n[5:3]} + {16'd0, w_n[2:1]};
      w_bx_last    = (r_plane == c_PL_Y) ? (r_bx == 6'd39) : (r_bx == 6'd19);
      w_by_last    = (r_by == 5'd29);
      w_dp_we_next = ((r_state == S_FETCH) || (r_state == S_DRAIN))
                     && (w_n >= 7'd2) && (w_n <= 7'd65);
   end

   // Even entries come straight off the SRAM bus, odd entries from the held low byte
   assign w_pix         = DP_address[0] ? r_low : SRAM_read_data[15:8];
   assign DP_write_data = DP_we ? {{24{~w_pix[7]}}, ~w_pix[7], w_pix[6:0]} : 32'd0;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         r_state      <= S_IDLE;
         r_cyc        <= 7'd0;
         r_plane      <= c_PL_Y;
         r_bx         <= 6'd0;
         r_by         <= 5'd0;
         r_low        <= 8'd0;
         SRAM_address <= 18'd0;
         DP_address   <= 7'd0;
         DP_we        <= 1'b0;
         Busy         <= 1'b0;
         Block_done   <= 1'b0;
         Frame_done   <= 1'b0;
      end else begin
         Block_done <= 1'b0;
         Frame_done <= 1'b0;
         DP_we      <= w_dp_we_next;
         if (w_dp_we_next)
            DP_address <= w_n - 7'd2;
         if (DP_we && !DP_address[0])
            r_low <= SRAM_read_data[7:0];

         case (r_state)
            S_IDLE: begin
               if (Start) begin
                  r_state      <= S_FETCH;
                  r_cyc        <= 7'd0;
                  Busy         <= 1'b1;
                  SRAM_address <= w_word_addr;
               end
            end
            S_FETCH: begin
               r_cyc <= w_n;
               if (!w_n[0] && (w_n < 7'd64))
                  SRAM_address <= w_word_addr;
               if (r_cyc == 7'd63)
                  r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               r_cyc <= w_n;
               if (r_cyc == 7'd65) begin
                  r_state    <= S_DONE;
                  Block_done <= 1'b1;
                  Frame_done <= (r_plane == c_PL_V) && w_bx_last && w_by_last;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_cyc   <= 7'd0;
               Busy    <= 1'b0;
               if (w_bx_last) begin
                  r_bx <= 6'd0;
                  if (w_by_last) begin
                     r_by <= 5'd0;
                     case (r_plane)
                        c_PL_Y:  r_plane <= c_PL_U;
                        c_PL_U:  r_plane <= c_PL_V;
                        default: r_plane <= c_PL_Y;
                     endcase
                  end else begin
                     r_by <= r_by + 5'd1;
                  end
               end else begin
                  r_bx <= r_bx + 6'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_yuv_block_reader.sv
// ============================================================================
//  Module   : tb_yuv_block_reader
//  Function : Self-checking bench for yuv_block_reader against a frame-level model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_yuv_block_reader;

   logic        Clock = 1'b0;
   logic        Resetn = 1'b0;
   logic        Start = 1'b0;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_read_data;
   logic        SRAM_we_n;
   logic [6:0]  DP_address;
   logic [31:0] DP_write_data;
   logic        DP_we;
   logic        Busy;
   logic        Block_done;
   logic        Frame_done;

   int tests_run = 0;
   int tests_failed = 0;

   logic [15:0] mem [0:76799];
   logic [17:0] a1 = 18'd0;
   logic [17:0] a2 = 18'd0;

   int          blk_idx = 0;   // block the model expects next (0..2399)
   logic [17:0] last_base;
   logic [31:0] last_dp0, last_dp1;

   yuv_block_reader dut (
      .Clock(Clock), .Resetn(Resetn), .Start(Start),
      .SRAM_address(SRAM_address), .SRAM_read_data(SRAM_read_data),
      .SRAM_we_n(SRAM_we_n), .DP_address(DP_address), .DP_write_data(DP_write_data),
      .DP_we(DP_we), .Busy(Busy), .Block_done(Block_done), .Frame_done(Frame_done)
   );

   always #5 Clock = ~Clock;

   // SRAM with two cycles of read latency
   always @(posedge Clock) begin
      a1 <= SRAM_address;
      a2 <= a1;
   end
   assign SRAM_read_data = (a2 < 18'd76800) ? mem[a2] : 16'hxxxx;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int exp_stride(input int n);
      return (n < 1200) ? 160 : 80;
   endfunction

   function automatic int exp_base(input int n);
      int m;
      if (n < 1200) return (n / 40) * 1280 + (n % 40) * 4;
      if (n < 1800) begin
         m = n - 1200;
         return 38400 + (m / 20) * 640 + (m % 20) * 4;
      end
      m = n - 1800;
      return 57600 + (m / 20) * 640 + (m % 20) * 4;
   endfunction

   function automatic int exp_addr(input int n, input int w);
      return exp_base(n) + (w / 4) * exp_stride(n) + (w % 4);
   endfunction

   function automatic logic [31:0] exp_dp(input int n, input int i);
      logic [15:0] word;
      logic [7:0]  pix;
      word = mem[exp_addr(n, i / 2)];
      pix  = (i % 2 == 0) ? word[15:8] : word[7:0];
      return 32'(int'(pix) - 128);
   endfunction

   // Runs one block from a negedge in IDLE and checks it against the model.
   // repulse >= 0 raises Start again in that cycle of the fetch.
   task automatic check_block(input int repulse);
      int  we_cnt, done_cnt, done_cyc, frame_cyc, bad_addr, bad_dp, busy_end, busy0;
      logic [17:0] got_addr;
      logic [31:0] got_dp;
      logic [6:0]  got_dpa;
      we_cnt = 0; done_cnt = 0; done_cyc = -1; frame_cyc = -1;
      bad_addr = -1; bad_dp = -1; busy_end = 1; busy0 = 0;
      got_addr = '0; got_dp = '0; got_dpa = '0;
      Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      for (int c = 0; c < 68; c++) begin
         Start = (c == repulse);
         if (c == 0) busy0 = Busy;
         if (c == 67) busy_end = Busy;
         if (c < 64 && c % 2 == 0) begin
            if (c == 0) last_base = SRAM_address;
            if (bad_addr < 0 && SRAM_address !== 18'(exp_addr(blk_idx, c / 2))) begin
               bad_addr = c / 2; got_addr = SRAM_address;
            end
         end
         if (DP_we === 1'b1) begin
            we_cnt++;
            if (c == 2) last_dp0 = DP_write_data;
            if (c == 3) last_dp1 = DP_write_data;
            if (bad_dp < 0 && (c < 2 || c > 65 || DP_address !== 7'(c - 2)
                               || DP_write_data !== exp_dp(blk_idx, c - 2))) begin
               bad_dp = c; got_dp = DP_write_data; got_dpa = DP_address;
            end
         end
         if (Block_done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (Frame_done === 1'b1 && frame_cyc < 0) frame_cyc = c;
         @(negedge Clock);
      end
      Start = 1'b0;

      tests_run++;
      if (busy0 !== 1) begin
         tests_failed++;
         $display("FAIL busy_start blk %0d: got %0d want 1", blk_idx, busy0);
      end
      tests_run++;
      if (bad_addr >= 0) begin
         tests_failed++;
         $display("FAIL addr_seq blk %0d word %0d: got %0d want %0d",
                  blk_idx, bad_addr, got_addr, exp_addr(blk_idx, bad_addr));
      end
      tests_run++;
      if (bad_dp >= 0) begin
         tests_failed++;
         $display("FAIL dp_write blk %0d cycle %0d: got addr %0d data %h want addr %0d data %h",
                  blk_idx, bad_dp, got_dpa, got_dp, bad_dp - 2,
                  (bad_dp >= 2 && bad_dp <= 65) ? exp_dp(blk_idx, bad_dp - 2) : 32'hx);
      end
      tests_run++;
      if (we_cnt != 64) begin
         tests_failed++;
         $display("FAIL dp_we_count blk %0d: got %0d want 64", blk_idx, we_cnt);
      end
      tests_run++;
      if (done_cyc != 66 || done_cnt != 1) begin
         tests_failed++;
         $display("FAIL block_done blk %0d: got cycle %0d count %0d want cycle 66 count 1",
                  blk_idx, done_cyc, done_cnt);
      end
      tests_run++;
      if (frame_cyc != ((blk_idx == 2399) ? 66 : -1)) begin
         tests_failed++;
         $display("FAIL frame_done blk %0d: got cycle %0d want %0d",
                  blk_idx, frame_cyc, (blk_idx == 2399) ? 66 : -1);
      end
      tests_run++;
      if (busy_end !== 0) begin
         tests_failed++;
         $display("FAIL busy_end blk %0d: got %0d want 0", blk_idx, busy_end);
      end
      blk_idx = (blk_idx + 1) % 2400;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      Resetn = 1'b0;
      repeat (3) @(negedge Clock);
      tests_run++;
      if ({SRAM_address, SRAM_we_n, DP_address, DP_write_data, DP_we, Busy, Block_done, Frame_done}
          !== {18'd0, 1'b1, 7'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_outputs: got addr %0d we_n %b dpa %0d dpd %h dpwe %b busy %b done %b frame %b want 0 1 0 0 0 0 0 0",
                  SRAM_address, SRAM_we_n, DP_address, DP_write_data, DP_we, Busy, Block_done, Frame_done);
      end
      Resetn = 1'b1;
      repeat (2) @(negedge Clock);
      tests_run++;
      if (Busy !== 1'b0 || DP_we !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_no_start: got busy %b dp_we %b want 0 0", Busy, DP_we);
      end
      blk_idx = 0;
   endtask

   task automatic test_first_block;
      mem[0] = 16'h8000;
      check_block(-1);
      tests_run++;
      if (last_dp0 !== 32'h00000000 || last_dp1 !== 32'hFFFFFF80) begin
         tests_failed++;
         $display("FAIL dp_8000: got %h %h want 00000000 ffffff80", last_dp0, last_dp1);
      end
      tests_run++;
      if (last_base !== 18'd0) begin
         tests_failed++;
         $display("FAIL base_blk0: got %0d want 0", last_base);
      end
   endtask

   task automatic test_ff7f;
      mem[exp_addr(blk_idx, 0)] = 16'hFF7F;
      check_block(-1);
      tests_run++;
      if (last_dp0 !== 32'h0000007F || last_dp1 !== 32'hFFFFFFFF) begin
         tests_failed++;
         $display("FAIL dp_ff7f: got %h %h want 0000007f ffffffff", last_dp0, last_dp1);
      end
   endtask

   task automatic test_row_wrap;
      while (blk_idx < 41) begin
         check_block(-1);
         if (blk_idx == 40) begin
            tests_run++;
            if (last_base !== 18'd156) begin
               tests_failed++;
               $display("FAIL base_blk39: got %0d want 156", last_base);
            end
         end
      end
      tests_run++;
      if (last_base !== 18'd1280) begin
         tests_failed++;
         $display("FAIL base_blk40: got %0d want 1280", last_base);
      end
   endtask

   task automatic test_plane_switch;
      while (blk_idx < 1801) begin
         check_block(-1);
         if (blk_idx == 1201) begin
            tests_run++;
            if (last_base !== 18'd38400) begin
               tests_failed++;
               $display("FAIL base_u0: got %0d want 38400", last_base);
            end
         end
      end
      tests_run++;
      if (last_base !== 18'd57600) begin
         tests_failed++;
         $display("FAIL base_v0: got %0d want 57600", last_base);
      end
   endtask

   task automatic test_frame_wrap;
      while (blk_idx != 0) check_block(-1);   // last iteration is block 2399 with Frame_done
      check_block(-1);
      tests_run++;
      if (last_base !== 18'd0) begin
         tests_failed++;
         $display("FAIL base_after_frame: got %0d want 0", last_base);
      end
   endtask

   task automatic test_start_ignored;
      check_block(10);
      check_block(66);
      check_block(-1);   // position must have advanced by exactly one per block
   endtask

   task automatic test_reset_abort;
      Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
      repeat (30) @(negedge Clock);
      tests_run++;
      if (DP_we !== 1'b1) begin
         tests_failed++;
         $display("FAIL dp_we_before_abort: got %b want 1", DP_we);
      end
      Resetn = 1'b0;
      #1;
      tests_run++;
      if (DP_we !== 1'b0 || Busy !== 1'b0 || DP_write_data !== 32'd0 || SRAM_address !== 18'd0) begin
         tests_failed++;
         $display("FAIL abort_async: got dp_we %b busy %b dpd %h addr %0d want 0 0 0 0",
                  DP_we, Busy, DP_write_data, SRAM_address);
      end
      @(negedge Clock);
      @(negedge Clock);
      tests_run++;
      if (DP_we !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_hold: got dp_we %b want 0", DP_we);
      end
      Resetn = 1'b1;
      @(negedge Clock);
      tests_run++;
      if (DP_we !== 1'b0 || Busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_release: got dp_we %b busy %b want 0 0", DP_we, Busy);
      end
      blk_idx = 0;
      check_block(-1);
      tests_run++;
      if (last_base !== 18'd0) begin
         tests_failed++;
         $display("FAIL base_after_abort: got %0d want 0", last_base);
      end
   endtask

   initial begin
      for (int i = 0; i < 76800; i++) mem[i] = 16'($urandom);
      @(negedge Clock);
      test_reset;
      test_first_block;
      test_ff7f;
      test_row_wrap;
      test_plane_switch;
      test_frame_wrap;
      test_start_ignored;
      test_reset_abort;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

`default_nettype wire
